// File: rtl/iddmm_word_serial.sv
// iddmm_word_serial: runtime-sized word-serial Montgomery multiplier, R = X*Y*2^(-K*n) mod P in [0, P)
// Ports: ld_en/ld_sel/ld_addr/ld_data write X, Y or P words while IDLE; start latches n_words and
//        p1 (-P^-1 mod 2^K) and launches an operation; busy is high outside IDLE; res_valid/res_ready/
//        res_addr/res_data stream the reduced result LSW first; done pulses once at the end, with err
//        set when n_words was out of range.
module iddmm_word_serial #(
   parameter int K      = 128,
   parameter int N_MAX  = 32,
   parameter int ADDR_W = $clog2(N_MAX)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_en,
   input  logic [1:0]        ld_sel,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [K-1:0]      ld_data,
   input  logic [K-1:0]      p1,
   input  logic [ADDR_W:0]   n_words,
   input  logic              start,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ADDR_W-1:0] res_addr,
   output logic [K-1:0]      res_data,
   output logic              done,
   output logic              err
);
   localparam logic [2:0] S_IDLE = 3'd0, S_MUL = 3'd1, S_SUB = 3'd2, S_OUT = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;
   localparam logic [ADDR_W:0] N_LIM = (ADDR_W+1)'(N_MAX);
   localparam int UW = 2*K+2;
   logic [K-1:0] x_m [N_MAX];
   logic [K-1:0] y_m [N_MAX];
   logic [K-1:0] p_m [N_MAX];
   logic [K-1:0] d_m [N_MAX];
   logic [K-1:0] a_m [N_MAX+1];
   logic [2:0] state;
   logic [ADDR_W:0] n_r, j;
   logic [ADDR_W-1:0] i, jw;
   logic [K-1:0] p1_r, q_r, t_lo, q_new, q;
   logic [K:0] c, diff;
   logic [UW-1:0] u;
   logic bw, sel_d, in_row;
   assign jw     = j[ADDR_W-1:0];
   assign in_row = j < n_r;
   assign busy      = state != S_IDLE;
   assign res_valid = state == S_OUT;
   assign res_addr  = (state == S_OUT) ? jw : '0;
   assign res_data  = (state == S_OUT) ? (sel_d ? d_m[jw] : a_m[j]) : '0;
   // Column j of row i; at j=0 the quotient digit is formed from the fresh low word
   // and held in q_r for the remaining columns. Column n only folds the carry into A[n].
   always_comb begin
      t_lo  = a_m[0] + x_m[0] * y_m[i];
      q_new = t_lo * p1_r;
      q     = (j == '0) ? q_new : q_r;
      u     = UW'(a_m[j])
            + (in_row ? UW'(x_m[jw]) * UW'(y_m[i]) + UW'(q) * UW'(p_m[jw]) : '0)
            + ((j == '0) ? '0 : UW'(c));
      diff  = {1'b0, a_m[j]} - {1'b0, p_m[jw]} - (K+1)'(bw);
   end
   always_ff @(posedge clk) begin
      if (ld_en && state == S_IDLE) begin
         if (ld_sel == 2'd0) x_m[ld_addr] <= ld_data;
         else if (ld_sel == 2'd1) y_m[ld_addr] <= ld_data;
         else if (ld_sel == 2'd2) p_m[ld_addr] <= ld_data;
      end
      if (state == S_SUB) d_m[jw] <= diff[K-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         done  <= 1'b0;
         err   <= 1'b0;
         n_r   <= '0;
         i     <= '0;
         j     <= '0;
         c     <= '0;
         bw    <= 1'b0;
         sel_d <= 1'b0;
         for (int m = 0; m <= N_MAX; m++) a_m[m] <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               if (n_words != '0 && n_words <= N_LIM) begin
                  state <= S_MUL;
                  n_r   <= n_words;
                  p1_r  <= p1;
                  i     <= '0;
                  j     <= '0;
                  for (int m = 0; m <= N_MAX; m++) a_m[m] <= '0;
               end else state <= S_ERR;
            end
            S_MUL: begin
               c <= (K+1)'(u >> K);
               if (j == '0) q_r <= q_new;
               else a_m[j - 1'b1] <= u[K-1:0];
               if (j == n_r) begin
                  a_m[j] <= {{(K-1){1'b0}}, u[K]};
                  j      <= '0;
                  if ({1'b0, i} == n_r - 1'b1) begin
                     state <= S_SUB;
                     bw    <= 1'b0;
                  end else i <= i + 1'b1;
               end else j <= j + 1'b1;
            end
            S_SUB: begin
               bw <= diff[K];
               if (j == n_r - 1'b1) begin
                  // A >= P exactly when the extra top word is set or no borrow escaped.
                  sel_d <= (|a_m[n_r]) | !diff[K];
                  j     <= '0;
                  state <= S_OUT;
               end else j <= j + 1'b1;
            end
            S_OUT: if (res_ready) begin
               if (j == n_r - 1'b1) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else j <= j + 1'b1;
            end
            S_DONE: state <= S_IDLE;
            S_ERR: begin
               state <= S_IDLE;
               done  <= 1'b1;
               err   <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iddmm_word_serial.sv
// tb_iddmm_word_serial: randomized and directed checks of iddmm_word_serial against a bit-serial Montgomery model
module tb_iddmm_word_serial;
   localparam int K = 16, N_MAX = 4, AW = 2;
   logic clk = 1'b0, rst, ld_en, start, busy, res_valid, res_ready, done, err;
   logic [1:0] ld_sel;
   logic [AW-1:0] ld_addr, res_addr;
   logic [K-1:0] ld_data, p1, res_data;
   logic [AW:0] n_words;
   int checks = 0, errors = 0, cyc = 0;
   logic [15:0] exp_words [8];
   int exp_n, st_cyc, nxt, last_x;
   bit exp_err, op_on = 0, seen_valid, got_done, ready_hi;
   always #5 clk = ~clk;
   iddmm_word_serial #(.K(K), .N_MAX(N_MAX), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .p1(p1), .n_words(n_words), .start(start), .busy(busy), .res_valid(res_valid),
      .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data), .done(done), .err(err));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc - st_cyc);
      end
   endtask
   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc - st_cyc);
   endtask
   // X*Y*2^(-16n) mod P by halving modulo P once per bit.
   function automatic logic [63:0] mont(input logic [63:0] x, y, p, input int n);
      logic [127:0] r;
      r = (128'(x) * 128'(y)) % 128'(p);
      for (int b = 0; b < 16 * n; b++) begin
         if (r[0]) r = r + 128'(p);
         r = r >> 1;
      end
      return r[63:0];
   endfunction
   function automatic logic [15:0] neg_inv(input logic [15:0] p0);
      logic [15:0] v;
      v = p0;
      for (int k = 0; k < 4; k++) v = v * (16'd2 - p0 * v);
      return -v;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [1:0] sel, input int a, input logic [15:0] d);
      ld_en = 1'b1; ld_sel = sel; ld_addr = a[AW-1:0]; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask
   initial forever begin
      @(posedge clk);
      cyc++;
   end
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (op_on && !exp_err) chk("busy", busy, cyc != st_cyc);
         if (op_on && exp_err) chk("busy_err", busy, (cyc - st_cyc) == 1);
         if (res_valid) begin
            if (!op_on || exp_err) flag("stray_valid");
            else begin
               if (!seen_valid) begin
                  seen_valid = 1;
                  if (ready_hi) chk("first_valid_cycle", cyc - st_cyc, exp_n * (exp_n + 1) + exp_n + 1);
               end
               chk("res_addr", res_addr, nxt);
               chk("res_data", res_data, exp_words[nxt]);
               if (res_ready) begin
                  nxt++;
                  last_x = cyc;
               end
            end
         end
         if (done) begin
            if (!op_on) flag("stray_done");
            else begin
               chk("err", err, exp_err);
               if (exp_err) chk("err_done_cycle", cyc - st_cyc, 2);
               else begin
                  chk("words_out", nxt, exp_n);
                  chk("done_after_last", cyc - last_x, 1);
                  if (ready_hi) chk("done_cycle", cyc - st_cyc, exp_n * (exp_n + 1) + 2 * exp_n + 1);
               end
               op_on = 0;
               got_done = 1;
            end
         end
      end
   end
   task automatic run_op(input logic [63:0] x, y, p, input int n, input int mode, input bit reload);
      logic [63:0] r;
      int sc;
      if (reload)
         for (int w = 0; w < n; w++) begin
            load(2'd0, w, x[16*w+:16]);
            load(2'd1, w, y[16*w+:16]);
            load(2'd2, w, p[16*w+:16]);
         end
      r = mont(x, y, p, n);
      for (int w = 0; w < 8; w++) exp_words[w] = (w < 4) ? r[16*w+:16] : 16'h0;
      exp_n = n; exp_err = 0; nxt = 0; seen_valid = 0; got_done = 0; ready_hi = (mode == 0); last_x = 0; sc = 0;
      p1 = neg_inv(p[15:0]);
      n_words = n[AW:0];
      res_ready = (mode == 0);
      start = 1'b1; st_cyc = cyc; op_on = 1;
      tick();
      for (int t = 0; t < 300 && !got_done; t++) begin
         start = (t == 0);
         ld_en = (t == 0); ld_sel = 2'd2; ld_addr = '0; ld_data = p[15:0] ^ 16'h0102;
         if (mode == 1) begin
            if (seen_valid) sc++;
            res_ready = (sc > 5) && (sc % 2 == 0);
         end else if (mode == 2) res_ready = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0; ld_en = 1'b0;
      if (!got_done) begin
         flag("timeout");
         op_on = 0;
      end
   endtask
   task automatic run_err(input int nw);
      exp_err = 1; exp_n = 0; got_done = 0;
      n_words = nw[AW:0];
      res_ready = 1'b1;
      start = 1'b1; st_cyc = cyc; op_on = 1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 10 && !got_done; t++) tick();
      if (!got_done) begin
         flag("err_timeout");
         op_on = 0;
      end
      tick();
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [63:0] rx, ry, rp, mask;
      int rn;
      rst = 1; ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; p1 = 0; n_words = 0; start = 0; res_ready = 0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", res_addr, 0);
      chk("rst_data", res_data, 0);
      rst = 0;
      chk("model_p1", neg_inv(16'hFFF1), 16'hEEEF);
      chk("model_1x1", mont(64'd1, 64'd1, 64'hFFF1, 1), 16'hEEE1);
      chk("model_f_1234", mont(64'h000F, 64'h1234, 64'hFFF1, 1), 16'h1234);
      chk("model_fff0_f", mont(64'hFFF0, 64'h000F, 64'hFFF1, 1), 16'hFFF0);
      chk("model_zero", mont(64'd0, 64'd0, 64'hFFF1, 1), 16'h0000);
      chk("model_n2", mont(64'h00E1, 64'h1234, 64'hFFF1, 2), 32'h0000_1234);
      run_op(64'd1, 64'd1, 64'hFFF1, 1, 0, 1);
      run_op(64'h000F, 64'h1234, 64'hFFF1, 1, 0, 1);
      run_op(64'hFFF0, 64'h000F, 64'hFFF1, 1, 0, 1);
      run_op(64'd0, 64'd0, 64'hFFF1, 1, 0, 1);
      run_op(64'h00E1, 64'h1234, 64'hFFF1, 2, 0, 1);
      run_op(64'h00E1, 64'h1234, 64'hFFF1, 2, 1, 0);
      run_op(64'h00E1, 64'h1234, 64'hFFF1, 2, 2, 0);
      run_err(0);
      run_err(5);
      run_err(7);
      n_words = 3'd4; p1 = 16'hEEEF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", res_valid, 0);
      chk("midrst_done", done, 0);
      repeat (40) tick();
      run_op(64'd1, 64'd1, 64'hFFF1, 1, 0, 1);
      for (int k = 0; k < 30; k++) begin
         rn = $urandom_range(1, 4);
         mask = (rn == 4) ? '1 : ((64'd1 << (16 * rn)) - 64'd1);
         rp = ({$urandom, $urandom} & mask) | 64'd1;
         if ($urandom_range(0, 1) == 1) rp = rp | (64'd1 << (16 * rn - 1));
         rx = {$urandom, $urandom} % rp;
         ry = {$urandom, $urandom} % rp;
         run_op(rx, ry, rp, rn, $urandom_range(0, 2), 1);
      end
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
